// File: rtl/uart_tx_scheduler_pkg.sv
// Shared UART scheduler types: FSM state encoding,
// byte width and a clog2 helper for sizing.
package uart_tx_scheduler_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } sched_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter_comb.sv
// Combinational round-robin pick: first set req bit searching from last+1 with wrap.
// Ports: req, last -> gnt (one-hot), gnt_idx, any_req.
module rr_arbiter_comb
  import uart_tx_scheduler_pkg::*;
#(
  parameter int N = 4,
  parameter int W = clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         any_req
);

  logic         found;
  logic [W-1:0] cand;

  assign any_req = |req;

  always_comb begin
    gnt     = '0;
    gnt_idx = last;
    found   = 1'b0;
    cand    = '0;
    for (int i = 1; i <= N; i++) begin
      cand = W'((int'(last) + i) % N);
      if (!found && req[cand]) begin
        found        = 1'b1;
        gnt[cand]    = 1'b1;
        gnt_idx      = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ producers.
// Ports: clk/rst, req_valid/req_data/req_ready, tx_start/tx_data/tx_done,
// grant_id, busy, err_timeout/err_clr.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int DONE_TIMEOUT = 4096
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [8*NUM_REQ-1:0]      req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_start,
  output logic [7:0]                tx_data,
  input  logic                      tx_done,
  output logic [clog2(NUM_REQ)-1:0] grant_id,
  output logic                      busy,
  output logic                      err_timeout,
  input  logic                      err_clr
);

  localparam int IW  = clog2(NUM_REQ);
  localparam int TW  = clog2(DONE_TIMEOUT) + 1;
  localparam int GC  = clog2(GAP_CYCLES + 1);
  localparam int GW  = (GC < 1) ? 1 : GC;

  sched_state_e  state_q, state_d;
  logic [TW-1:0] to_q, to_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          err_set;

  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gidx;
  logic               any_req;

  rr_arbiter_comb #(
    .N (NUM_REQ),
    .W (IW)
  ) u_arb (
    .req     (req_valid),
    .last    (grant_id),
    .gnt     (gnt),
    .gnt_idx (gidx),
    .any_req (any_req)
  );

  // Outputs are masked while rst is high so nothing escapes mid-reset.
  assign req_ready = (state_q == IDLE && !rst) ? gnt : '0;
  assign tx_start  = (state_q == START) && !rst;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    to_d    = to_q;
    gap_d   = gap_q;
    err_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) state_d = START;
      end
      START: begin
        to_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (tx_done || to_q == TW'(DONE_TIMEOUT - 1)) begin
          // A timeout abandons the byte and exits like a normal done.
          err_set = !tx_done;
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
            gap_d   = GW'(GAP_CYCLES);
          end
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      GAP: begin
        gap_d = gap_q - 1'b1;
        if (gap_q <= GW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      to_q        <= '0;
      gap_q       <= '0;
      tx_data     <= 8'h00;
      grant_id    <= IW'(NUM_REQ - 1);
      err_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      to_q    <= to_d;
      gap_q   <= gap_d;
      if (state_q == IDLE && any_req) begin
        tx_data  <= req_data[BYTE_W*int'(gidx) +: BYTE_W];
        grant_id <= gidx;
      end
      if (err_set) begin
        err_timeout <= 1'b1;
      end else if (err_clr) begin
        err_timeout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler
// (NUM_REQ=4, GAP_CYCLES=2, DONE_TIMEOUT=16).
module tb_uart_tx_scheduler;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic [1:0]  grant_id;
  logic        busy;
  logic        err_timeout;
  logic        err_clr;

  int checks = 0;
  int errors = 0;

  uart_tx_scheduler #(
    .NUM_REQ      (4),
    .GAP_CYCLES   (2),
    .DONE_TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .busy        (busy),
    .err_timeout (err_timeout),
    .err_clr     (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed no_finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] byte_of(input int i);
    return req_data[8*i +: 8];
  endfunction

  // At an IDLE cycle with req_valid set: check the grant, the start
  // pulse, then return tx_done dly cycles after tx_start and walk the gap.
  task automatic serve(input int id, input int dly);
    #1;
    chk("accept_ready", 32'(req_ready), 32'(4'b0001 << id));
    tick();
    chk("start_pulse", 32'(tx_start), 32'd1);
    chk("start_gid", 32'(grant_id), 32'(id));
    chk("start_data", 32'(tx_data), 32'(byte_of(id)));
    tick();
    chk("wait_no_start", 32'(tx_start), 32'd0);
    repeat (dly - 1) tick();
    chk("wait_data_hold", 32'(tx_data), 32'(byte_of(id)));
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    #1;
    chk("gap_no_ready", 32'(req_ready), 32'd0);
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'b0000;
    req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    tx_done   = 1'b0;
    err_clr   = 1'b0;
    tick();
    tick();

    // Reset values, and no ready while rst is high.
    req_valid     = 4'b0001;
    req_data[7:0] = 8'hA5;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_start", 32'(tx_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd3);
    chk("rst_data", 32'(tx_data), 32'h00);
    chk("rst_err", 32'(err_timeout), 32'd0);

    // Single request from requester 0.
    tick();
    rst = 1'b0;
    #1;
    chk("t1_ready", 32'(req_ready), 32'b0001);
    tick();
    #1;
    chk("t1_ready_once", 32'(req_ready), 32'd0);
    chk("t1_start", 32'(tx_start), 32'd1);
    chk("t1_data", 32'(tx_data), 32'hA5);
    chk("t1_gid", 32'(grant_id), 32'd0);
    req_valid = 4'b0000;
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    tick();
    #1;
    chk("t1_idle", 32'(busy), 32'd0);
    chk("t1_data_hold", 32'(tx_data), 32'hA5);

    // Fresh reset, then all four valid: order 0,1,2,3,0 spaced 10+2+1.
    req_data[7:0] = 8'hA0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 4'b1111;
    serve(0, 10);
    serve(1, 10);
    serve(2, 10);
    serve(3, 10);
    serve(0, 10);

    // Requesters 1 and 3 only, then requester 1 withdraws.
    req_valid = 4'b0010;
    serve(1, 3);
    req_valid = 4'b1010;
    serve(3, 3);
    serve(1, 3);
    req_valid = 4'b1000;
    serve(3, 3);

    // No tx_done: timeout after 16 cycles, sticky until err_clr.
    req_valid = 4'b0001;
    #1;
    chk("to_ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("to_start", 32'(tx_start), 32'd1);
    repeat (15) tick();
    chk("to_err_early", 32'(err_timeout), 32'd0);
    tick();
    tick();
    chk("to_err_set", 32'(err_timeout), 32'd1);
    tick();
    tick();
    tick();
    chk("to_idle", 32'(busy), 32'd0);
    chk("to_err_sticky", 32'(err_timeout), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1;
    chk("to_err_clr", 32'(err_timeout), 32'd0);

    // Spurious tx_done in START and in GAP is ignored.
    req_valid = 4'b0010;
    #1;
    chk("sp_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b0000;
    tx_done   = 1'b1;
    #1;
    chk("sp_start", 32'(tx_start), 32'd1);
    tick();
    tx_done = 1'b0;
    repeat (4) tick();
    chk("sp_start_done_ign", 32'(busy), 32'd1);
    repeat (3) tick();
    tx_done = 1'b1;
    tick();
    tick();
    tx_done = 1'b0;
    #1;
    chk("sp_gap_done_ign", 32'(busy), 32'd1);
    tick();
    chk("sp_idle", 32'(busy), 32'd0);
    chk("sp_no_err", 32'(err_timeout), 32'd0);

    // Reset in WAIT with all requesters valid.
    req_valid = 4'b1111;
    #1;
    chk("rw_ready", 32'(req_ready), 32'b0100);
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rw_rst_ready", 32'(req_ready), 32'd0);
    chk("rw_rst_start", 32'(tx_start), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rw_busy", 32'(busy), 32'd0);
    chk("rw_gid", 32'(grant_id), 32'd3);
    chk("rw_no_start", 32'(tx_start), 32'd0);
    chk("rw_first_ready", 32'(req_ready), 32'b0001);
    tick();
    chk("rw_start", 32'(tx_start), 32'd1);
    chk("rw_gid0", 32'(grant_id), 32'd0);
    chk("rw_data", 32'(tx_data), 32'hA0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
